// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM states, byte ordering
// within a word, and the legality rule for the high byte of a word.
package loader_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_LO    = 3'd2,
    ST_HI    = 3'd3,
    ST_WRITE = 3'd4,
    ST_CSUM  = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_e;

  // Order in which the two bytes of a word arrive on the stream.
  localparam int LO_BYTE = 0;
  localparam int HI_BYTE = 1;

  // Bits that may be set in the high byte of a 15-bit instruction.
  localparam logic [7:0] HI_LEGAL_MASK = 8'h7F;

  // A high byte is legal when it sets no bit outside the instruction width.
  function automatic logic hi_byte_legal(input logic [7:0] hi);
    return ((hi & ~HI_LEGAL_MASK) == 8'h00);
  endfunction

  // States in which the loader takes a byte from the stream.
  function automatic logic accepts_byte(input state_e st);
    case (st)
      ST_COUNT, ST_LO, ST_HI, ST_CSUM: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/program_loader_checksum.sv
// XOR accumulator for frame bytes. Clear has priority over enable so a
// frame restart always begins from zero.
module frame_checksum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] sum
);

  logic [7:0] sum_d;
  logic [7:0] sum_q;

  // Next accumulator value: clear, fold in a byte, or hold.
  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = 8'h00;
    end else if (en) begin
      sum_d = sum_q ^ data;
    end else begin
      sum_d = sum_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/program_loader.sv
// Loads the instruction memory from a byte stream framed as
// count, {LO, HI} per word, XOR checksum. Holds the core frozen until a
// frame has been written completely and its checksum has matched.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  // Word count for a count byte of zero: the whole memory.
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_WORD   = {{ADDR_W{1'b0}}, 1'b1};

  state_e              state_d,   state_q;
  logic [ADDR_W:0]     count_d,   count_q;
  logic [7:0]          lo_d,      lo_q;
  logic [ADDR_W-1:0]   addr_d,    addr_q;
  logic [WORD_W-1:0]   wdata_d,   wdata_q;
  logic [ADDR_W:0]     words_d,   words_q;
  logic                hold_d,    hold_q;
  logic                busy_d,    busy_q;
  logic                done_d,    done_q;
  logic                error_d,   error_q;
  logic                ready_d,   ready_q;
  logic                we_d,      we_q;

  logic                accept_s;
  logic                csum_clr_s;
  logic                csum_en_s;
  logic [7:0]          csum_s;
  logic [ADDR_W:0]     words_inc_s;
  logic [7:0]          frame_bytes_s [2];

  // A byte moves only when the loader is ready and the source offers one.
  assign accept_s    = rx_valid & ready_q;
  assign words_inc_s = words_q + ONE_WORD;

  // The latched low byte and the high byte on the bus form the word.
  assign frame_bytes_s[LO_BYTE] = lo_q;
  assign frame_bytes_s[HI_BYTE] = rx_data;

  frame_checksum u_checksum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (csum_clr_s),
    .en    (csum_en_s),
    .data  (rx_data),
    .sum   (csum_s)
  );

  // Next-state and next-output logic of the loader FSM.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    lo_d       = lo_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    words_d    = words_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    csum_clr_s = 1'b0;
    csum_en_s  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_COUNT;
          done_d     = 1'b0;
          error_d    = 1'b0;
          words_d    = {(ADDR_W+1){1'b0}};
          addr_d     = {ADDR_W{1'b0}};
          hold_d     = 1'b1;
          busy_d     = 1'b1;
          csum_clr_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end

      ST_COUNT: begin
        if (accept_s) begin
          csum_en_s = 1'b1;
          if (rx_data[ADDR_W-1:0] == {ADDR_W{1'b0}}) begin
            count_d = FULL_COUNT;
          end else begin
            count_d = {1'b0, rx_data[ADDR_W-1:0]};
          end
          state_d = ST_LO;
        end else begin
          state_d = ST_COUNT;
        end
      end

      ST_LO: begin
        if (accept_s) begin
          csum_en_s = 1'b1;
          lo_d      = rx_data;
          state_d   = ST_HI;
        end else begin
          state_d = ST_LO;
        end
      end

      ST_HI: begin
        if (accept_s) begin
          csum_en_s = 1'b1;
          if (!hi_byte_legal(rx_data)) begin
            // High byte would not fit the instruction: abort the frame.
            state_d = ST_ERR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            wdata_d = {frame_bytes_s[HI_BYTE][WORD_W-9:0], frame_bytes_s[LO_BYTE]};
            state_d = ST_WRITE;
          end
        end else begin
          state_d = ST_HI;
        end
      end

      ST_WRITE: begin
        // Address wraps naturally; only a full-memory frame reaches it.
        addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        words_d = words_inc_s;
        if (words_inc_s == count_q) begin
          state_d = ST_CSUM;
        end else begin
          state_d = ST_LO;
        end
      end

      ST_CSUM: begin
        if (accept_s) begin
          if (rx_data == csum_s) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            hold_d  = 1'b0;
          end else begin
            state_d = ST_ERR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          state_d = ST_CSUM;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake and write strobe are registered from the next state so
    // they line up exactly with the state they belong to.
    ready_d = accepts_byte(state_d);
    we_d    = (state_d == ST_WRITE);
  end

  // Loader state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= {(ADDR_W+1){1'b0}};
      lo_q    <= 8'h00;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {WORD_W{1'b0}};
      words_q <= {(ADDR_W+1){1'b0}};
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lo_q    <= lo_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      words_q <= words_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      ready_q <= ready_d;
      we_q    <= we_d;
    end
  end

  assign rx_ready     = ready_q;
  assign im_we        = we_q;
  assign im_addr      = addr_q;
  assign im_wdata     = wdata_q;
  assign core_hold    = hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader. Expected memory writes are queued as
// bytes are sent and compared when the loader strobes im_we.
`timescale 1ns/1ps
module tb_program_loader;

  localparam int ADDR_W = 8;
  localparam int WORD_W = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [WORD_W-1:0] im_wdata;
  logic              core_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  program_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .core_hold    (core_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } wr_t;

  wr_t        exp_q [$];
  int         checks   = 0;
  int         failures = 0;
  int         we_count = 0;
  logic [7:0] frame_lo [256];
  logic [7:0] frame_hi [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && im_we === 1'b1) begin
      wr_t e;
      we_count++;
      chk("write_was_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(im_addr), 32'(e.addr));
        chk("write_data", 32'(im_wdata), 32'(e.data));
      end
    end
  end

  // Offer one byte after `gap` idle cycles; bounded wait for the handshake.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (rx_ready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    rx_valid = 1'b0;
    chk("byte_accepted", 32'(ok), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Send a whole frame of n words from frame_lo/frame_hi; csum_flip
  // corrupts the checksum byte when non-zero.
  task automatic send_frame(input int n, input logic [7:0] csum_flip, input int gap);
    logic [7:0] cnt;
    logic [7:0] cs;
    cnt = 8'(n);
    cs  = cnt;
    send_byte(cnt, gap);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(wr_t'{addr: ADDR_W'(k), data: {frame_hi[k][6:0], frame_lo[k]}});
      send_byte(frame_lo[k], gap);
      send_byte(frame_hi[k], gap);
      cs = cs ^ frame_lo[k] ^ frame_hi[k];
    end
    send_byte(cs ^ csum_flip, gap);
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev;
    int bad_ready;
    int bad_hold;

    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_hold", 32'(core_hold), 32'd1);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_im_we", 32'(im_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_im_addr", 32'(im_addr), 32'd0);
    chk("rst_im_wdata", 32'(im_wdata), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Idle without start: core held, nothing accepted, nothing written.
    prev      = we_count;
    bad_ready = 0;
    bad_hold  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rx_ready !== 1'b0) bad_ready++;
      if (core_hold !== 1'b1) bad_hold++;
    end
    chk("idle_rx_ready_cycles", 32'(bad_ready), 32'd0);
    chk("idle_core_hold_cycles", 32'(bad_hold), 32'd0);
    chk("idle_writes", 32'(we_count - prev), 32'd0);
    @(posedge clk); #1;

    // Good two-word frame.
    frame_lo[0] = 8'h34; frame_hi[0] = 8'h12;
    frame_lo[1] = 8'h00; frame_hi[1] = 8'h7F;
    prev = we_count;
    pulse_start();
    chk("a_busy", 32'(busy), 32'd1);
    chk("a_hold", 32'(core_hold), 32'd1);
    send_frame(2, 8'h00, 0);
    chk("a_done", 32'(done), 32'd1);
    chk("a_core_hold", 32'(core_hold), 32'd0);
    chk("a_busy_end", 32'(busy), 32'd0);
    chk("a_error", 32'(error), 32'd0);
    chk("a_words", 32'(words_loaded), 32'd2);
    chk("a_im_addr", 32'(im_addr), 32'd2);
    chk("a_writes", 32'(we_count - prev), 32'd2);
    chk("a_queue_empty", 32'(exp_q.size()), 32'd0);

    // Same frame, checksum 5A instead of 5B.
    prev = we_count;
    pulse_start();
    chk("b_done_cleared", 32'(done), 32'd0);
    chk("b_hold_set", 32'(core_hold), 32'd1);
    send_frame(2, 8'h01, 0);
    chk("b_error", 32'(error), 32'd1);
    chk("b_core_hold", 32'(core_hold), 32'd1);
    chk("b_done", 32'(done), 32'd0);
    chk("b_writes", 32'(we_count - prev), 32'd2);
    chk("b_queue_empty", 32'(exp_q.size()), 32'd0);

    // Illegal HI byte on the first word.
    prev = we_count;
    pulse_start();
    chk("c_error_cleared", 32'(error), 32'd0);
    send_byte(8'h01, 0);
    send_byte(8'h34, 0);
    send_byte(8'h80, 0);
    chk("c_error", 32'(error), 32'd1);
    chk("c_rx_ready", 32'(rx_ready), 32'd0);
    chk("c_core_hold", 32'(core_hold), 32'd1);
    chk("c_busy", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("c_rx_ready_later", 32'(rx_ready), 32'd0);
    chk("c_writes", 32'(we_count - prev), 32'd0);
    chk("c_words", 32'(words_loaded), 32'd0);

    // Full-memory frame: count byte 00 means 256 words.
    for (int k = 0; k < 256; k++) begin
      frame_lo[k] = 8'(k);
      frame_hi[k] = 8'(k) & 8'h7F;
    end
    prev = we_count;
    pulse_start();
    send_frame(256, 8'h00, 0);
    chk("d_done", 32'(done), 32'd1);
    chk("d_error", 32'(error), 32'd0);
    chk("d_words", 32'(words_loaded), 32'd256);
    chk("d_im_addr_wrap", 32'(im_addr), 32'd0);
    chk("d_writes", 32'(we_count - prev), 32'd256);
    chk("d_queue_empty", 32'(exp_q.size()), 32'd0);

    // Stalled frame, interrupted by reset after the first write.
    frame_lo[0] = 8'hA5; frame_hi[0] = 8'h3C;
    frame_lo[1] = 8'h5A; frame_hi[1] = 8'h41;
    frame_lo[2] = 8'hFF; frame_hi[2] = 8'h7F;
    prev = we_count;
    pulse_start();
    send_byte(8'h03, 2);
    exp_q.push_back(wr_t'{addr: 8'h00, data: {frame_hi[0][6:0], frame_lo[0]}});
    send_byte(frame_lo[0], 2);
    send_byte(frame_hi[0], 3);
    for (int i = 0; i < 20 && we_count == prev; i++) begin
      @(posedge clk); #1;
    end
    chk("e_first_write", 32'(we_count - prev), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("e_rst_core_hold", 32'(core_hold), 32'd1);
    chk("e_rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("e_rst_busy", 32'(busy), 32'd0);
    chk("e_rst_im_addr", 32'(im_addr), 32'd0);
    chk("e_rst_words", 32'(words_loaded), 32'd0);
    chk("e_rst_im_we", 32'(im_we), 32'd0);
    chk("e_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("e_idle_hold", 32'(core_hold), 32'd1);

    // Restarted frame with rx_valid toggling between bytes.
    prev = we_count;
    pulse_start();
    send_frame(3, 8'h00, 1);
    chk("f_done", 32'(done), 32'd1);
    chk("f_core_hold", 32'(core_hold), 32'd0);
    chk("f_words", 32'(words_loaded), 32'd3);
    chk("f_writes", 32'(we_count - prev), 32'd3);
    chk("f_queue_empty", 32'(exp_q.size()), 32'd0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
